// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT address sequencer: FSM state encoding,
// width helpers derived from LOG2N and the bit-reversal used for load addresses.
package fft_pkg;

    localparam int MAX_LOG2N = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_e;

    function automatic int n_of(input int log2n);
        return 1 << log2n;
    endfunction

    function automatic int stage_width(input int log2n);
        return $clog2(log2n);
    endfunction

    // Reverses the low 'width' bits of v; bits above 'width' come back as zero.
    function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] v,
                                                    input int width);
        logic [MAX_LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_LOG2N; i++) begin
            for (int j = 0; j < MAX_LOG2N; j++) begin
                if ((i < width) && (i + j == width - 1)) begin
                    r[i] = v[j];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_addr_sequencer_if.sv
// Bundle of the sequencer's control, load and butterfly-command signals.
// master = host/butterfly side driving requests, slave = the sequencer.
interface fft_addr_sequencer_if
    import fft_pkg::*;
#(
    parameter int LOG2N = 10
) ();

    logic                               start;
    logic                               idle;
    logic                               done;
    logic                               load_valid;
    logic                               load_ready;
    logic [LOG2N-1:0]                   load_addr;
    logic                               bf_valid;
    logic                               bf_ready;
    logic [LOG2N-1:0]                   bf_addr_a;
    logic [LOG2N-1:0]                   bf_addr_b;
    logic [LOG2N-2:0]                   bf_twiddle;
    logic [stage_width(LOG2N)-1:0]      bf_stage;

    modport master (
        output start, load_valid, bf_ready,
        input  idle, done, load_ready, load_addr,
               bf_valid, bf_addr_a, bf_addr_b, bf_twiddle, bf_stage
    );

    modport slave (
        input  start, load_valid, bf_ready,
        output idle, done, load_ready, load_addr,
               bf_valid, bf_addr_a, bf_addr_b, bf_twiddle, bf_stage
    );

endinterface

// File: rtl/fft_bf_addr_gen.sv
// Combinational radix-2 DIT butterfly address and twiddle generator for
// stage s, butterfly index b (inputs arrive bit-reversed, outputs in order).
module fft_bf_addr_gen
    import fft_pkg::*;
#(
    parameter int LOG2N = 10,
    parameter int SW    = stage_width(LOG2N)
) (
    input  logic [SW-1:0]    s_i,
    input  logic [LOG2N-2:0] b_i,
    output logic [LOG2N-1:0] addr_a_o,
    output logic [LOG2N-1:0] addr_b_o,
    output logic [LOG2N-2:0] twiddle_o
);

    logic [LOG2N-1:0] b_ext;
    logic [LOG2N-1:0] span;
    logic [LOG2N-1:0] pos;
    logic [LOG2N-1:0] group_base;
    logic [SW:0]      s_plus1;
    logic [SW-1:0]    tw_shift;

    always_comb begin
        b_ext      = {1'b0, b_i};
        span       = LOG2N'(1) << s_i;
        pos        = b_ext & (span - LOG2N'(1));
        s_plus1    = {1'b0, s_i} + (SW+1)'(1);
        // Each group of 'span' butterflies covers 2*span consecutive points.
        group_base = (b_ext >> s_i) << s_plus1;
        addr_a_o   = group_base | pos;
        addr_b_o   = addr_a_o + span;
        tw_shift   = SW'(LOG2N - 1) - s_i;
        twiddle_o  = (LOG2N-1)'(pos << tw_shift);
    end

endmodule

// File: rtl/fft_addr_sequencer.sv
// In-place radix-2 FFT address sequencer: loads N samples at bit-reversed
// addresses, then issues LOG2N stages of butterflies with a drain gap per stage.
module fft_addr_sequencer
    import fft_pkg::*;
#(
    parameter int LOG2N  = 10,
    parameter int BF_LAT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          idle,
    output logic                          done,
    input  logic                          load_valid,
    output logic                          load_ready,
    output logic [LOG2N-1:0]              load_addr,
    output logic                          bf_valid,
    input  logic                          bf_ready,
    output logic [LOG2N-1:0]              bf_addr_a,
    output logic [LOG2N-1:0]              bf_addr_b,
    output logic [LOG2N-2:0]              bf_twiddle,
    output logic [stage_width(LOG2N)-1:0] bf_stage
);

    localparam int SW  = stage_width(LOG2N);
    localparam int CW  = LOG2N;
    localparam int BW  = LOG2N - 1;
    localparam int DW  = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

    localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
    localparam logic [DW-1:0] D_LAST = DW'(BF_LAT - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] c_q, c_d;
    logic [BW-1:0] b_q, b_d;
    logic [SW-1:0] s_q, s_d;
    logic [DW-1:0] drain_q, drain_d;

    logic [LOG2N-1:0] gen_a;
    logic [LOG2N-1:0] gen_b;
    logic [LOG2N-2:0] gen_tw;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            c_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            b_q     <= b_d;
            s_q     <= s_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        c_d        = c_q;
        b_d        = b_q;
        s_d        = s_q;
        drain_d    = drain_q;
        idle       = 1'b0;
        done       = 1'b0;
        load_ready = 1'b0;
        bf_valid   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                idle = 1'b1;
                if (start) begin
                    state_d = ST_LOAD;
                    c_d     = '0;
                    b_d     = '0;
                    s_d     = '0;
                end
            end
            ST_LOAD: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    if (c_q == '1) begin
                        c_d     = '0;
                        b_d     = '0;
                        s_d     = '0;
                        state_d = ST_ISSUE;
                    end else begin
                        c_d = c_q + CW'(1);
                    end
                end
            end
            ST_ISSUE: begin
                bf_valid = 1'b1;
                if (bf_ready) begin
                    if (b_q == '1) begin
                        drain_d = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        b_d = b_q + BW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                // Lets the last write-backs of this stage land before the next reads them.
                if (drain_q == D_LAST) begin
                    if (s_q == S_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        s_d     = s_q + SW'(1);
                        b_d     = '0;
                        state_d = ST_ISSUE;
                    end
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                b_d     = '0;
                s_d     = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    fft_bf_addr_gen #(
        .LOG2N (LOG2N),
        .SW    (SW)
    ) u_bf_addr_gen (
        .s_i       (s_q),
        .b_i       (b_q),
        .addr_a_o  (gen_a),
        .addr_b_o  (gen_b),
        .twiddle_o (gen_tw)
    );

    always_comb begin
        load_addr  = '0;
        bf_addr_a  = '0;
        bf_addr_b  = '0;
        bf_twiddle = '0;
        bf_stage   = s_q;
        if (state_q == ST_LOAD) begin
            load_addr = LOG2N'(bitrev(MAX_LOG2N'(c_q), LOG2N));
        end
        if (state_q == ST_ISSUE) begin
            bf_addr_a  = gen_a;
            bf_addr_b  = gen_b;
            bf_twiddle = gen_tw;
        end
    end

endmodule

// File: tb/tb_fft_addr_sequencer.sv
// Self-checking bench for fft_addr_sequencer at LOG2N=3, BF_LAT=2: directed
// vector tables, stall/abort sequences and randomized handshakes vs. a model.
module tb_fft_addr_sequencer;

    localparam int LOG2N  = 3;
    localparam int BF_LAT = 2;
    localparam int N      = 8;

    typedef struct {
        logic       lv;
        logic [2:0] exp_addr;
    } load_vec_t;

    typedef struct {
        logic       rdy;
        logic [2:0] a;
        logic [2:0] b;
        logic [1:0] tw;
        logic [1:0] st;
    } bf_vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_addr_sequencer_if #(.LOG2N(LOG2N)) bus ();

    fft_addr_sequencer #(
        .LOG2N  (LOG2N),
        .BF_LAT (BF_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (bus.start),
        .idle       (bus.idle),
        .done       (bus.done),
        .load_valid (bus.load_valid),
        .load_ready (bus.load_ready),
        .load_addr  (bus.load_addr),
        .bf_valid   (bus.bf_valid),
        .bf_ready   (bus.bf_ready),
        .bf_addr_a  (bus.bf_addr_a),
        .bf_addr_b  (bus.bf_addr_b),
        .bf_twiddle (bus.bf_twiddle),
        .bf_stage   (bus.bf_stage)
    );

    int checks   = 0;
    int failures = 0;

    int load_exp[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int bfa_exp[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int bfb_exp[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int tw_exp[12]  = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    load_vec_t load_tbl[8];
    bf_vec_t   bf_tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Reference: butterfly idx = stage*(N/2) + b, built from group/offset arithmetic.
    function automatic bf_vec_t model_cmd(input int idx);
        bf_vec_t r;
        int s, bb, span, pos;
        s    = idx / (N / 2);
        bb   = idx % (N / 2);
        span = 2 ** s;
        pos  = bb % span;
        r.rdy = 1'b1;
        r.a   = 3'((bb / span) * 2 * span + pos);
        r.b   = 3'((bb / span) * 2 * span + pos + span);
        r.tw  = 2'(pos * ((N / 2) / span));
        r.st  = 2'(s);
        return r;
    endfunction

    function automatic int brev(input int v);
        int r;
        int x;
        r = 0;
        x = v;
        for (int i = 0; i < LOG2N; i++) begin
            r = r * 2 + x % 2;
            x = x / 2;
        end
        return r;
    endfunction

    function automatic logic [31:0] pack_exp(input bf_vec_t e);
        return 32'({1'b1, e.a, e.b, e.tw, e.st});
    endfunction

    function automatic logic [31:0] pack_dut();
        return 32'({bus.bf_valid, bus.bf_addr_a, bus.bf_addr_b, bus.bf_twiddle, bus.bf_stage});
    endfunction

    task automatic begin_and_load();
        bus.start      = 1'b1;
        bus.load_valid = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        bus.load_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int seen;
        seen = 0;
        for (int w = 0; w < 100 && seen == 0; w++) begin
            if (bus.done) seen = 1;
            @(negedge clk);
        end
        check(name, 32'(seen), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, gap, done_at, found, hit, seen1, nd, lc, hs;
        bf_vec_t exp_q[$];
        bf_vec_t e;

        for (int i = 0; i < 8; i++) begin
            load_tbl[i].lv       = 1'b1;
            load_tbl[i].exp_addr = 3'(load_exp[i]);
        end
        for (int i = 0; i < 12; i++) begin
            bf_tbl[i].rdy = 1'b1;
            bf_tbl[i].a   = 3'(bfa_exp[i]);
            bf_tbl[i].b   = 3'(bfb_exp[i]);
            bf_tbl[i].tw  = 2'(tw_exp[i]);
            bf_tbl[i].st  = 2'(i / 4);
        end

        // Reset state
        rst = 1'b1; bus.start = 1'b0; bus.load_valid = 1'b0; bus.bf_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_idle",       32'(bus.idle),       32'd1);
        check("rst_done",       32'(bus.done),       32'd0);
        check("rst_load_ready", 32'(bus.load_ready), 32'd0);
        check("rst_bf_valid",   32'(bus.bf_valid),   32'd0);
        check("rst_load_addr",  32'(bus.load_addr),  32'd0);
        check("rst_bf_addrs",   pack_dut(),          32'd0);

        // rst wins over start
        bus.start = 1'b1;
        @(negedge clk);
        check("rst_prio_idle", 32'(bus.idle),       32'd1);
        check("rst_prio_load", 32'(bus.load_ready), 32'd0);

        // Directed transform: bit-reversed loads, no stalls, start held high meanwhile
        rst = 1'b0; bus.start = 1'b1; bus.load_valid = 1'b1; bus.bf_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.load_valid = load_tbl[i].lv;
            check("load_ready", 32'(bus.load_ready), 32'd1);
            check($sformatf("load_addr[%0d]", i), 32'(bus.load_addr), 32'(load_tbl[i].exp_addr));
            $display("LOAD c=%0d addr=%0d", i, bus.load_addr);
            @(negedge clk);
        end
        bus.load_valid = 1'b0;
        check("issue_entry", 32'(bus.bf_valid), 32'd1);
        k = 0; gap = 0; done_at = -1;
        for (int t = 8; t < 60 && done_at < 0; t++) begin
            if (t == 20) bus.start = 1'b0;
            if (bus.bf_valid) begin
                if (k > 0 && k % 4 == 0) check("stage_gap", 32'(gap), 32'(BF_LAT));
                if (k < 12) begin
                    bus.bf_ready = bf_tbl[k].rdy;
                    check($sformatf("bf_cmd[%0d]", k), pack_dut(), pack_exp(bf_tbl[k]));
                end else begin
                    check("bf_extra_cmd", 32'(k), 32'd12);
                end
                $display("BF s=%0d a=%0d b=%0d tw=%0d", bus.bf_stage, bus.bf_addr_a,
                         bus.bf_addr_b, bus.bf_twiddle);
                k++;
                gap = 0;
            end else if (bus.done) begin
                done_at = t;
                check("final_gap", 32'(gap), 32'(BF_LAT));
            end else begin
                gap++;
            end
            @(negedge clk);
        end
        check("bf_cmd_count", 32'(k), 32'd12);
        check("done_latency", 32'(done_at + 1), 32'd27);
        check("post_done_idle", 32'({bus.idle, bus.done}), 32'b10);
        $display("DONE at cycle %0d after start", done_at + 1);

        // Stall at stage 1, b=2: outputs hold for 5 cycles
        bus.bf_ready = 1'b1;
        begin_and_load();
        found = 0;
        for (int t = 0; t < 40 && found == 0; t++) begin
            if (bus.bf_valid && bus.bf_stage == 2'd1 && bus.bf_addr_a == 3'd4) found = 1;
            else @(negedge clk);
        end
        check("stall_point_reached", 32'(found), 32'd1);
        bus.bf_ready = 1'b0;
        e = bf_tbl[6];
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall_hold[%0d]", i), pack_dut(), pack_exp(e));
            @(negedge clk);
        end
        bus.bf_ready = 1'b1;
        check("stall_release", pack_dut(), pack_exp(e));
        $display("BF stall released a=%0d b=%0d tw=%0d", bus.bf_addr_a, bus.bf_addr_b, bus.bf_twiddle);
        @(negedge clk);
        check("after_stall", pack_dut(), pack_exp(bf_tbl[7]));
        $display("BF s=%0d a=%0d b=%0d tw=%0d", bus.bf_stage, bus.bf_addr_a, bus.bf_addr_b, bus.bf_twiddle);
        wait_done("stall_done_seen");

        // Reset during stage-1 drain aborts with no done pulse
        begin_and_load();
        seen1 = 0; hit = 0;
        for (int t = 0; t < 40 && hit == 0; t++) begin
            if (bus.bf_valid && bus.bf_stage == 2'd1) seen1 = 1;
            else if (seen1 == 1 && !bus.bf_valid) hit = 1;
            if (hit == 0) @(negedge clk);
        end
        check("drain1_reached", 32'(hit), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_state", 32'({bus.idle, bus.done, bus.load_ready, bus.bf_valid}), 32'b1000);
        check("abort_stage", 32'(bus.bf_stage), 32'd0);
        $display("ABORT in drain, idle=%0d", bus.idle);
        nd = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        check("no_done_after_abort", 32'(nd), 32'd0);

        // Randomized load gaps and butterfly back-pressure vs. reference model
        for (int tr = 0; tr < 4; tr++) begin
            exp_q = {};
            for (int idx = 0; idx < 12; idx++) exp_q.push_back(model_cmd(idx));
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            lc = 0;
            for (int w = 0; w < 200 && lc < 8; w++) begin
                bus.load_valid = ($urandom_range(0, 3) != 0);
                bus.start      = $urandom_range(0, 1);
                check("rnd_load", 32'({bus.load_ready, bus.load_addr}), 32'({1'b1, 3'(brev(lc))}));
                if (bus.load_valid) begin
                    $display("LOAD tr=%0d c=%0d addr=%0d", tr, lc, bus.load_addr);
                    lc++;
                end
                @(negedge clk);
            end
            bus.load_valid = 1'b0;
            check("rnd_load_count", 32'(lc), 32'd8);
            for (int st = 0; st < 3; st++) begin
                for (int bb = 0; bb < 4; bb++) begin
                    e  = exp_q.pop_front();
                    hs = 0;
                    for (int w = 0; w < 50 && hs == 0; w++) begin
                        bus.bf_ready = ($urandom_range(0, 2) != 0);
                        bus.start    = $urandom_range(0, 1);
                        check("rnd_bf_cmd", pack_dut(), pack_exp(e));
                        if (bus.bf_ready) begin
                            hs = 1;
                            $display("BF tr=%0d s=%0d a=%0d b=%0d tw=%0d", tr, bus.bf_stage,
                                     bus.bf_addr_a, bus.bf_addr_b, bus.bf_twiddle);
                        end
                        @(negedge clk);
                    end
                    check("rnd_bf_handshake", 32'(hs), 32'd1);
                end
                bus.bf_ready = $urandom_range(0, 1);
                bus.start    = 1'b0;
                gap = 0;
                for (int w = 0; w < 20 && !bus.bf_valid && !bus.done; w++) begin
                    gap++;
                    @(negedge clk);
                end
                check("rnd_drain_len", 32'(gap), 32'(BF_LAT));
            end
            check("rnd_done", 32'({bus.done, bus.idle, bus.bf_valid}), 32'b100);
            $display("DONE tr=%0d", tr);
            @(negedge clk);
            check("rnd_idle", 32'({bus.done, bus.idle}), 32'b01);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
